// File: rtl/mul_result_fifo.sv
// mul_result_fifo: small first-word-fall-through queue that captures one product from an
// upstream shift-add multiplier per completion, i.e. per rising edge of the level-sensitive
// done_i flag.
//
// Parameters:
//   W     - product width in bits
//   DEPTH - number of entries (power of two, >= 2)
//
// Ports:
//   clk_i   - clock, all state updates on the rising edge
//   rst_i   - synchronous active-low reset
//   prod_i  - product bus from the multiplier
//   done_i  - multiplier completion flag (level, held while prod_i is stable)
//   data_o  - head-of-queue product (zero while the queue is empty)
//   valid_o - data_o holds a valid entry
//   ready_i - consumer accepts data_o this cycle
//   count_o - current occupancy
//   full_o  - occupancy equals DEPTH
//   ovf_o   - sticky dropped-push flag, present only when MUL_RESULT_FIFO_OVF_EN is defined
//
// Optional feature macro: MUL_RESULT_FIFO_OVF_EN
module mul_result_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [W-1:0]             prod_i,
  input  logic                     done_i,
  output logic [W-1:0]             data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
`ifdef MUL_RESULT_FIFO_OVF_EN
  output logic                     full_o,
  output logic                     ovf_o
`else
  output logic                     full_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_done;

  logic          w_valid;
  logic          w_full;
  logic          w_push_evt;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  // Outputs derive only from registered state.
  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // One capture per completion: only the rising edge of done_i counts.
  assign w_push_evt = done_i & ~r_done;
  assign w_pop      = w_valid & ready_i;
  // When full, a simultaneous pop frees the slot being written.
  assign w_push     = w_push_evt & (~w_full | w_pop);
  assign w_drop     = w_push_evt & w_full & ~w_pop;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      // Treat done_i as already high so a level held across reset is not captured.
      r_done  <= 1'b1;
    end else begin
      r_done <= done_i;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage has no reset; stale entries are masked by the occupancy count.
  always_ff @(posedge clk_i) begin
    if (rst_i && w_push) r_mem[r_wptr] <= prod_i;
  end

`ifdef MUL_RESULT_FIFO_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf_o = r_ovf;
`else
  logic w_unused_drop;
  assign w_unused_drop = w_drop;
`endif

  assign data_o  = w_valid ? r_mem[r_rptr] : '0;
  assign valid_o = w_valid;
  assign count_o = r_count;
  assign full_o  = w_full;

endmodule

// File: tb/tb_mul_result_fifo.sv
module tb_mul_result_fifo;

  logic        clk;
  logic        rst;
  logic [15:0] prod;
  logic        done;
  logic [15:0] data;
  logic        valid;
  logic        ready;
  logic [2:0]  count;
  logic        full;
`ifdef MUL_RESULT_FIFO_OVF_EN
  logic        ovf;
`endif

  int total;
  int bad;

  mul_result_fifo #(
    .W     (16),
    .DEPTH (4)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .prod_i  (prod),
    .done_i  (done),
    .data_o  (data),
    .valid_o (valid),
    .ready_i (ready),
    .count_o (count),
`ifdef MUL_RESULT_FIFO_OVF_EN
    .full_o  (full),
    .ovf_o   (ovf)
`else
    .full_o  (full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst   = 1'b0;
    done  = 1'b0;
    ready = 1'b0;
    prod  = 16'h0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic push_one(input logic [15:0] v, input logic rdy);
    prod  = v;
    done  = 1'b1;
    ready = rdy;
    tick();
    done  = 1'b0;
    ready = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst   = 1'b0;
    done  = 1'b0;
    ready = 1'b0;
    prod  = 16'hBEEF;
    tick();
    total++;
    if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    total++;
    if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full); end
    total++;
    if (data !== 16'h0) begin bad++; $display("FAIL reset_data: got %h want 0000", data); end
`ifdef MUL_RESULT_FIFO_OVF_EN
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single;
    do_reset();
    prod  = 16'h1234;
    done  = 1'b1;
    ready = 1'b0;
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL single_pre_valid: got %b want 0", valid); end
    tick();
    total++;
    if (valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", valid); end
    total++;
    if (data !== 16'h1234) begin bad++; $display("FAIL single_data: got %h want 1234", data); end
    total++;
    if (count !== 3'd1) begin bad++; $display("FAIL single_count: got %0d want 1", count); end
    // done_i stays high; must not capture again, and head must hold with ready low.
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (count !== 3'd1 || valid !== 1'b1 || data !== 16'h1234) begin
        bad++;
        $display("FAIL single_hold: got cnt=%0d v=%b d=%h want cnt=1 v=1 d=1234",
                 count, valid, data);
      end
    end
    done  = 1'b0;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    total++;
    if (valid !== 1'b0 || count !== 3'd0) begin
      bad++;
      $display("FAIL single_pop: got v=%b cnt=%0d want v=0 cnt=0", valid, count);
    end
  endtask

  task automatic test_order;
    do_reset();
    for (int v = 1; v <= 3; v++) push_one(16'(v), 1'b0);
    total++;
    if (full !== 1'b0 || count !== 3'd3) begin
      bad++;
      $display("FAIL order_three: got full=%b cnt=%0d want full=0 cnt=3", full, count);
    end
    push_one(16'd4, 1'b0);
    total++;
    if (full !== 1'b1 || count !== 3'd4) begin
      bad++;
      $display("FAIL order_full: got full=%b cnt=%0d want full=1 cnt=4", full, count);
    end
    ready = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      total++;
      if (valid !== 1'b1 || data !== 16'(v)) begin
        bad++;
        $display("FAIL order_pop: got v=%b d=%0d want v=1 d=%0d", valid, data, v);
      end
      tick();
    end
    ready = 1'b0;
    total++;
    if (valid !== 1'b0 || count !== 3'd0) begin
      bad++;
      $display("FAIL order_empty: got v=%b cnt=%0d want v=0 cnt=0", valid, count);
    end
  endtask

  task automatic test_overflow;
    do_reset();
    for (int v = 1; v <= 4; v++) push_one(16'(v), 1'b0);
    push_one(16'd5, 1'b0);
    total++;
    if (count !== 3'd4 || full !== 1'b1 || data !== 16'd1) begin
      bad++;
      $display("FAIL ovf_drop: got cnt=%0d full=%b d=%0d want cnt=4 full=1 d=1",
               count, full, data);
    end
`ifdef MUL_RESULT_FIFO_OVF_EN
    total++;
    if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", ovf); end
`endif
    ready = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      total++;
      if (valid !== 1'b1 || data !== 16'(v)) begin
        bad++;
        $display("FAIL ovf_drain: got v=%b d=%0d want v=1 d=%0d", valid, data, v);
      end
      tick();
    end
    ready = 1'b0;
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL ovf_empty: got v=%b want 0", valid); end
`ifdef MUL_RESULT_FIFO_OVF_EN
    total++;
    if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
`endif
  endtask

  task automatic test_back_to_back;
    do_reset();
    for (int v = 1; v <= 4; v++) push_one(16'(v), 1'b0);
    // Push of 5 coincides with pop of 1 while full.
    push_one(16'd5, 1'b1);
    total++;
    if (count !== 3'd4 || full !== 1'b1 || data !== 16'd2) begin
      bad++;
      $display("FAIL simul_state: got cnt=%0d full=%b d=%0d want cnt=4 full=1 d=2",
               count, full, data);
    end
`ifdef MUL_RESULT_FIFO_OVF_EN
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL simul_ovf: got %b want 0", ovf); end
`endif
    ready = 1'b1;
    for (int v = 2; v <= 5; v++) begin
      total++;
      if (valid !== 1'b1 || data !== 16'(v)) begin
        bad++;
        $display("FAIL simul_drain: got v=%b d=%0d want v=1 d=%0d", valid, data, v);
      end
      tick();
    end
    ready = 1'b0;
    total++;
    if (valid !== 1'b0 || count !== 3'd0) begin
      bad++;
      $display("FAIL simul_empty: got v=%b cnt=%0d want v=0 cnt=0", valid, count);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    push_one(16'h0011, 1'b0);
    push_one(16'h0022, 1'b0);
    push_one(16'h0033, 1'b0);
    total++;
    if (count !== 3'd3) begin bad++; $display("FAIL mid_fill: got %0d want 3", count); end
    prod = 16'h0044;
    done = 1'b1;
    rst  = 1'b0;
    tick();
    rst = 1'b1;
    total++;
    if (count !== 3'd0 || valid !== 1'b0 || data !== 16'h0) begin
      bad++;
      $display("FAIL mid_reset: got cnt=%0d v=%b d=%h want cnt=0 v=0 d=0000",
               count, valid, data);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (count !== 3'd0 || valid !== 1'b0) begin
        bad++;
        $display("FAIL mid_no_push: got cnt=%0d v=%b want cnt=0 v=0", count, valid);
      end
    end
    done = 1'b0;
    tick();
    prod = 16'h0055;
    done = 1'b1;
    tick();
    done = 1'b0;
    total++;
    if (count !== 3'd1 || valid !== 1'b1 || data !== 16'h0055) begin
      bad++;
      $display("FAIL mid_repush: got cnt=%0d v=%b d=%h want cnt=1 v=1 d=0055",
               count, valid, data);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    done  = 1'b0;
    ready = 1'b0;
    prod  = 16'h0;
    tick();
    test_reset();
    test_single();
    test_order();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
